// File: rtl/iob_uart_core_fifo.sv
// iob_uart_core_fifo: UART with configurable framing, TX/RX FIFOs, RTS/CTS flow control and sticky error flags
module iob_uart_core_fifo #(
    parameter int DIV_W      = 16,
    parameter int TXF_ADDR_W = 2,
    parameter int RXF_ADDR_W = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rst_soft_i,
    input  logic                  tx_en_i,
    input  logic                  rx_en_i,
    input  logic [1:0]            data_bits_i,
    input  logic [1:0]            parity_i,
    input  logic                  stop2_i,
    input  logic [DIV_W-1:0]      bit_duration_i,
    input  logic [7:0]            tx_data_i,
    input  logic                  data_write_en_i,
    output logic                  tx_ready_o,
    output logic                  tx_idle_o,
    output logic [7:0]            rx_data_o,
    output logic                  rx_ready_o,
    input  logic                  data_read_en_i,
    output logic [RXF_ADDR_W:0]   rx_level_o,
    input  logic                  err_clr_i,
    output logic                  parity_err_o,
    output logic                  frame_err_o,
    output logic                  overrun_err_o,
    input  logic                  rs232_rxd_i,
    output logic                  rs232_txd_o,
    input  logic                  rs232_cts_i,
    output logic                  rs232_rts_o
);
    localparam int RD = 2 ** RXF_ADDR_W;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic rst, rxd;
    assign rst = rst_i | rst_soft_i;
    // rxs_q[2] is one cycle older than the synchronised rxd and feeds start-edge detection
    logic [2:0] rxs_q;
    logic [1:0] cts_q;
    assign rxd = rxs_q[1];
    always_ff @(posedge clk_i) begin
        if (rst) begin
            rxs_q <= '1;
            cts_q <= '0;
        end else begin
            rxs_q <= {rxs_q[1:0], rs232_rxd_i};
            cts_q <= {cts_q[0], rs232_cts_i};
        end
    end
    logic [7:0]          txf_mem_q [2**TXF_ADDR_W];
    logic [TXF_ADDR_W-1:0] txf_wp_q, txf_rp_q;
    logic [TXF_ADDR_W:0]   txf_cnt_q;
    logic txf_full, txf_empty, txf_push, tx_pop;
    assign txf_full   = txf_cnt_q[TXF_ADDR_W];
    assign txf_empty  = txf_cnt_q == '0;
    assign txf_push   = data_write_en_i & ~txf_full;
    assign tx_ready_o = tx_en_i & ~txf_full & ~rst;
    always_ff @(posedge clk_i) if (txf_push) txf_mem_q[txf_wp_q] <= tx_data_i;
    always_ff @(posedge clk_i) begin
        if (rst) begin
            txf_wp_q  <= '0;
            txf_rp_q  <= '0;
            txf_cnt_q <= '0;
        end else begin
            txf_wp_q  <= txf_wp_q + TXF_ADDR_W'(txf_push);
            txf_rp_q  <= txf_rp_q + TXF_ADDR_W'(tx_pop);
            txf_cnt_q <= txf_cnt_q + (TXF_ADDR_W+1)'(txf_push) - (TXF_ADDR_W+1)'(tx_pop);
        end
    end
    state_t tx_st_q, tx_st_d;
    logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [7:0] tx_sh_q, tx_sh_d, tx_mask, tx_word;
    logic [1:0] tx_nb_q, tx_nb_d;
    logic tx_pen_q, tx_pen_d, tx_par_q, tx_par_d, tx_s2_q, tx_s2_d, txd_q, txd_d, tx_last;
    assign tx_mask     = 8'hFF >> (2'd3 - data_bits_i);
    assign tx_word     = txf_mem_q[txf_rp_q] & tx_mask;
    assign tx_last     = tx_cnt_q == tx_div_q - DIV_W'(1);
    assign tx_idle_o   = tx_en_i & txf_empty & (tx_st_q == IDLE) & ~rst;
    assign rs232_txd_o = txd_q;
    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_cnt_q + DIV_W'(1);
        tx_div_d = tx_div_q;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        tx_nb_d  = tx_nb_q;
        tx_pen_d = tx_pen_q;
        tx_par_d = tx_par_q;
        tx_s2_d  = tx_s2_q;
        tx_pop   = 1'b0;
        case (tx_st_q)
            IDLE: if (tx_en_i && !txf_empty && cts_q[1]) begin
                tx_pop   = 1'b1;
                tx_st_d  = START;
                tx_cnt_d = '0;
                tx_div_d = bit_duration_i;
                tx_nb_d  = data_bits_i;
                tx_pen_d = parity_i[0] ^ parity_i[1];
                tx_s2_d  = stop2_i;
                tx_sh_d  = tx_word;
                tx_par_d = ^tx_word ^ (parity_i == 2'd2);
            end
            START: if (tx_last) begin
                tx_st_d  = DATA;
                tx_cnt_d = '0;
                tx_bit_d = '0;
            end
            DATA: if (tx_last) begin
                tx_cnt_d = '0;
                tx_sh_d  = tx_sh_q >> 1;
                tx_bit_d = tx_bit_q + 3'd1;
                if (tx_bit_q == {1'b1, tx_nb_q}) begin
                    tx_st_d  = tx_pen_q ? PARITY : STOP;
                    tx_bit_d = '0;
                end
            end
            PARITY: if (tx_last) begin
                tx_st_d  = STOP;
                tx_cnt_d = '0;
                tx_bit_d = '0;
            end
            STOP: if (tx_last) begin
                tx_cnt_d = '0;
                tx_bit_d = 3'd1;
                tx_st_d  = (tx_s2_q && tx_bit_q == 3'd0) ? STOP : IDLE;
            end
            default: tx_st_d = IDLE;
        endcase
        // txd is registered from the next state so the start bit lands one cycle after the pop
        txd_d = (tx_st_d == START) ? 1'b0 : (tx_st_d == DATA) ? tx_sh_d[0] : (tx_st_d == PARITY) ? tx_par_d : 1'b1;
    end
    always_ff @(posedge clk_i) begin
        if (rst) begin
            tx_st_q  <= IDLE;
            tx_cnt_q <= '0;
            tx_div_q <= '0;
            tx_bit_q <= '0;
            tx_sh_q  <= '0;
            tx_nb_q  <= '0;
            tx_pen_q <= 1'b0;
            tx_par_q <= 1'b0;
            tx_s2_q  <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            tx_st_q  <= tx_st_d;
            tx_cnt_q <= tx_cnt_d;
            tx_div_q <= tx_div_d;
            tx_bit_q <= tx_bit_d;
            tx_sh_q  <= tx_sh_d;
            tx_nb_q  <= tx_nb_d;
            tx_pen_q <= tx_pen_d;
            tx_par_q <= tx_par_d;
            tx_s2_q  <= tx_s2_d;
            txd_q    <= txd_d;
        end
    end
    state_t rx_st_q, rx_st_d;
    logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_half;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic [1:0] rx_nb_q, rx_nb_d, rx_pm_q, rx_pm_d;
    logic rx_last, rx_push, perr_set, ferr_set;
    assign rx_last = rx_cnt_q == rx_div_q - DIV_W'(1);
    assign rx_half = (rx_div_q >> 1) - DIV_W'(1);
    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_cnt_q + DIV_W'(1);
        rx_div_d = rx_div_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_nb_d  = rx_nb_q;
        rx_pm_d  = rx_pm_q;
        rx_push  = 1'b0;
        perr_set = 1'b0;
        ferr_set = 1'b0;
        case (rx_st_q)
            IDLE: if (rx_en_i && rxs_q[2] && !rxd) begin
                rx_st_d  = START;
                rx_cnt_d = '0;
                rx_div_d = bit_duration_i;
                rx_nb_d  = data_bits_i;
                rx_pm_d  = parity_i;
                rx_sh_d  = '0;
            end
            START: if (rx_cnt_q == rx_half) begin
                rx_st_d  = rxd ? IDLE : DATA;
                rx_cnt_d = '0;
                rx_bit_d = '0;
            end
            DATA: if (rx_last) begin
                rx_cnt_d          = '0;
                rx_sh_d[rx_bit_q] = rxd;
                rx_bit_d          = rx_bit_q + 3'd1;
                if (rx_bit_q == {1'b1, rx_nb_q}) rx_st_d = (rx_pm_q[0] ^ rx_pm_q[1]) ? PARITY : STOP;
            end
            PARITY: if (rx_last) begin
                rx_st_d  = STOP;
                rx_cnt_d = '0;
                perr_set = rxd != (^rx_sh_q ^ (rx_pm_q == 2'd2));
            end
            STOP: if (rx_last) begin
                rx_st_d  = IDLE;
                rx_push  = rx_en_i;
                ferr_set = ~rxd;
            end
            default: rx_st_d = IDLE;
        endcase
        if (!rx_en_i) rx_st_d = IDLE;
    end
    always_ff @(posedge clk_i) begin
        if (rst) begin
            rx_st_q  <= IDLE;
            rx_cnt_q <= '0;
            rx_div_q <= '0;
            rx_bit_q <= '0;
            rx_sh_q  <= '0;
            rx_nb_q  <= '0;
            rx_pm_q  <= '0;
        end else begin
            rx_st_q  <= rx_st_d;
            rx_cnt_q <= rx_cnt_d;
            rx_div_q <= rx_div_d;
            rx_bit_q <= rx_bit_d;
            rx_sh_q  <= rx_sh_d;
            rx_nb_q  <= rx_nb_d;
            rx_pm_q  <= rx_pm_d;
        end
    end
    logic [7:0]            rxf_mem_q [RD];
    logic [RXF_ADDR_W-1:0] rxf_wp_q, rxf_rp_q;
    logic [RXF_ADDR_W:0]   rxf_cnt_q;
    logic rxf_empty, rxf_full, rxf_pop, rxf_wr, ovr_set;
    logic rts_q, perr_q, ferr_q, ovr_q;
    assign rxf_empty = rxf_cnt_q == '0;
    assign rxf_full  = rxf_cnt_q[RXF_ADDR_W];
    assign rxf_pop   = data_read_en_i & ~rxf_empty;
    // a pop frees the slot a same-cycle push into a full FIFO needs
    assign rxf_wr    = rx_push & (~rxf_full | rxf_pop);
    assign ovr_set   = rx_push & rxf_full & ~rxf_pop;
    assign rx_data_o     = rxf_empty ? 8'h00 : rxf_mem_q[rxf_rp_q];
    assign rx_ready_o    = ~rxf_empty;
    assign rx_level_o    = rxf_cnt_q;
    assign rs232_rts_o   = rts_q;
    assign parity_err_o  = perr_q;
    assign frame_err_o   = ferr_q;
    assign overrun_err_o = ovr_q;
    always_ff @(posedge clk_i) if (rxf_wr) rxf_mem_q[rxf_wp_q] <= rx_sh_q;
    always_ff @(posedge clk_i) begin
        if (rst) begin
            rxf_wp_q  <= '0;
            rxf_rp_q  <= '0;
            rxf_cnt_q <= '0;
            rts_q     <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rxf_wp_q  <= rxf_wp_q + RXF_ADDR_W'(rxf_wr);
            rxf_rp_q  <= rxf_rp_q + RXF_ADDR_W'(rxf_pop);
            rxf_cnt_q <= rxf_cnt_q + (RXF_ADDR_W+1)'(rxf_wr) - (RXF_ADDR_W+1)'(rxf_pop);
            rts_q     <= rx_en_i && (rxf_cnt_q < (RXF_ADDR_W+1)'(RD - 1));
            perr_q    <= perr_set | (perr_q & ~err_clr_i);
            ferr_q    <= ferr_set | (ferr_q & ~err_clr_i);
            ovr_q     <= ovr_set | (ovr_q & ~err_clr_i);
        end
    end
endmodule

// File: tb/tb_iob_uart_core_fifo.sv
// tb_iob_uart_core_fifo: directed loopback and line-injection bench for iob_uart_core_fifo
module tb_iob_uart_core_fifo;
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    logic rst_i, rst_soft_i, tx_en_i, rx_en_i, stop2_i, data_write_en_i, data_read_en_i, err_clr_i;
    logic [1:0] data_bits_i, parity_i;
    logic [15:0] bit_duration_i;
    logic [7:0] tx_data_i, rx_data_o;
    logic tx_ready_o, tx_idle_o, rx_ready_o, parity_err_o, frame_err_o, overrun_err_o;
    logic [2:0] rx_level_o;
    logic rxd, txd, cts, rts;
    logic loop = 1'b1, inj = 1'b1, cts_drv = 1'b0;
    int checks = 0, failures = 0;
    int n, lows, starts;
    logic prev;
    logic [10:0] frame;
    logic [7:0] pats [6] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80};
    assign rxd = loop ? txd : inj;
    assign cts = loop ? rts : cts_drv;
    iob_uart_core_fifo dut (
        .clk_i(clk_i), .rst_i(rst_i), .rst_soft_i(rst_soft_i), .tx_en_i(tx_en_i), .rx_en_i(rx_en_i),
        .data_bits_i(data_bits_i), .parity_i(parity_i), .stop2_i(stop2_i), .bit_duration_i(bit_duration_i),
        .tx_data_i(tx_data_i), .data_write_en_i(data_write_en_i), .tx_ready_o(tx_ready_o), .tx_idle_o(tx_idle_o),
        .rx_data_o(rx_data_o), .rx_ready_o(rx_ready_o), .data_read_en_i(data_read_en_i), .rx_level_o(rx_level_o),
        .err_clr_i(err_clr_i), .parity_err_o(parity_err_o), .frame_err_o(frame_err_o),
        .overrun_err_o(overrun_err_o), .rs232_rxd_i(rxd), .rs232_txd_o(txd), .rs232_cts_i(cts), .rs232_rts_o(rts)
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask
    task automatic cfg(input logic [1:0] nb, input logic [1:0] par, input logic s2, input logic [15:0] div);
        data_bits_i = nb;
        parity_i = par;
        stop2_i = s2;
        bit_duration_i = div;
    endtask
    task automatic write_byte(input logic [7:0] b);
        tx_data_i = b;
        data_write_en_i = 1'b1;
        @(negedge clk_i);
        data_write_en_i = 1'b0;
    endtask
    task automatic pop();
        data_read_en_i = 1'b1;
        @(negedge clk_i);
        data_read_en_i = 1'b0;
    endtask
    task automatic wait_rx(input string tag);
        for (int i = 0; i < 2000 && !rx_ready_o; i++) @(negedge clk_i);
        check(tag, rx_ready_o, 1'b1);
    endtask
    task automatic wait_txd_low(input string tag);
        for (int i = 0; i < 200 && txd; i++) @(negedge clk_i);
        check(tag, txd, 1'b0);
    endtask
    task automatic inject(input logic [7:0] d, input int nb, input logic pon, input logic pv, input logic sv, input int div);
        inj = 1'b0;
        repeat (div) @(negedge clk_i);
        for (int i = 0; i < nb; i++) begin
            inj = d[i];
            repeat (div) @(negedge clk_i);
        end
        if (pon) begin
            inj = pv;
            repeat (div) @(negedge clk_i);
        end
        inj = sv;
        repeat (div) @(negedge clk_i);
        inj = 1'b1;
        repeat (div) @(negedge clk_i);
    endtask
    initial begin
        rst_i = 1'b1; rst_soft_i = 1'b0; tx_en_i = 1'b0; rx_en_i = 1'b0; err_clr_i = 1'b0;
        data_write_en_i = 1'b0; data_read_en_i = 1'b0; tx_data_i = 8'h00;
        cfg(2'd3, 2'd0, 1'b0, 16'd100);
        repeat (3) @(negedge clk_i);
        check("rst_txd", txd, 1'b1);
        check("rst_rts", rts, 1'b0);
        check("rst_tx_ready", tx_ready_o, 1'b0);
        check("rst_tx_idle", tx_idle_o, 1'b0);
        check("rst_rx_ready", rx_ready_o, 1'b0);
        check("rst_rx_data", rx_data_o, 8'h00);
        check("rst_rx_level", rx_level_o, 3'd0);
        check("rst_errs", {parity_err_o, frame_err_o, overrun_err_o}, 3'b000);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("tx_ready_disabled", tx_ready_o, 1'b0);
        tx_en_i = 1'b1; rx_en_i = 1'b1;
        repeat (10) @(negedge clk_i);
        check("rts_up", rts, 1'b1);
        check("tx_idle_en", tx_idle_o, 1'b1);
        for (int k = 0; k < 6; k++) begin
            write_byte(pats[k]);
            wait_txd_low("lb100_start");
            n = 0;
            while (!tx_idle_o && n < 3000) begin
                @(negedge clk_i);
                n++;
            end
            check("lb100_frame_len", n, 1000);
            wait_rx("lb100_rx_ready");
            check("lb100_data", rx_data_o, pats[k]);
            pop();
        end
        check("lb100_errs", {parity_err_o, frame_err_o, overrun_err_o}, 3'b000);
        cfg(2'd3, 2'd0, 1'b0, 16'd4);
        for (int k = 0; k < 256; k++) begin
            write_byte(8'(k));
            wait_rx("lb4_rx_ready");
            check("lb4_data", rx_data_o, k);
            pop();
        end
        check("lb4_errs", {parity_err_o, frame_err_o, overrun_err_o}, 3'b000);
        check("lb4_level", rx_level_o, 3'd0);
        repeat (20) @(negedge clk_i);
        cfg(2'd2, 2'd1, 1'b1, 16'd16);
        frame = 11'b11101001010;
        write_byte(8'hA5);
        wait_txd_low("7e2_start");
        repeat (8) @(negedge clk_i);
        for (int i = 0; i < 11; i++) begin
            check($sformatf("7e2_bit%0d", i), txd, frame[i]);
            repeat (16) @(negedge clk_i);
        end
        wait_rx("7e2_rx_ready");
        check("7e2_data", rx_data_o, 8'h25);
        check("7e2_errs", {parity_err_o, frame_err_o}, 2'b00);
        pop();
        loop = 1'b0;
        cfg(2'd3, 2'd2, 1'b0, 16'd16);
        repeat (10) @(negedge clk_i);
        inject(8'h3C, 8, 1'b1, 1'b0, 1'b1, 16);
        wait_rx("odd_rx_ready");
        check("odd_parity_err", parity_err_o, 1'b1);
        check("odd_data", rx_data_o, 8'h3C);
        check("odd_frame_err", frame_err_o, 1'b0);
        pop();
        err_clr_i = 1'b1;
        @(negedge clk_i);
        err_clr_i = 1'b0;
        check("odd_cleared", parity_err_o, 1'b0);
        cfg(2'd3, 2'd0, 1'b0, 16'd16);
        inject(8'h11, 8, 1'b0, 1'b0, 1'b1, 16);
        inject(8'h22, 8, 1'b0, 1'b0, 1'b1, 16);
        check("ovr_rts_lvl2", rts, 1'b1);
        inject(8'h33, 8, 1'b0, 1'b0, 1'b1, 16);
        check("ovr_level3", rx_level_o, 3'd3);
        check("ovr_rts_lvl3", rts, 1'b0);
        check("ovr_none_yet", overrun_err_o, 1'b0);
        inject(8'h44, 8, 1'b0, 1'b0, 1'b1, 16);
        inject(8'h55, 8, 1'b0, 1'b0, 1'b1, 16);
        check("ovr_level4", rx_level_o, 3'd4);
        check("ovr_flag", overrun_err_o, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            check("ovr_data", rx_data_o, 8'h11 * k);
            pop();
        end
        check("ovr_drained", rx_ready_o, 1'b0);
        check("ovr_rts_back", rts, 1'b1);
        err_clr_i = 1'b1;
        @(negedge clk_i);
        err_clr_i = 1'b0;
        check("ovr_cleared", overrun_err_o, 1'b0);
        cfg(2'd3, 2'd0, 1'b0, 16'd100);
        inj = 1'b0;
        repeat (20) @(negedge clk_i);
        inj = 1'b1;
        repeat (200) @(negedge clk_i);
        check("glitch_no_push", rx_level_o, 3'd0);
        check("glitch_no_flags", {parity_err_o, frame_err_o, overrun_err_o}, 3'b000);
        cfg(2'd3, 2'd0, 1'b0, 16'd16);
        inject(8'h5A, 8, 1'b0, 1'b0, 1'b0, 16);
        wait_rx("ferr_rx_ready");
        check("ferr_flag", frame_err_o, 1'b1);
        check("ferr_data", rx_data_o, 8'h5A);
        check("ferr_level", rx_level_o, 3'd1);
        rst_soft_i = 1'b1;
        @(negedge clk_i);
        rst_soft_i = 1'b0;
        check("soft_level", rx_level_o, 3'd0);
        check("soft_ferr", frame_err_o, 1'b0);
        check("soft_data", rx_data_o, 8'h00);
        cfg(2'd3, 2'd0, 1'b0, 16'd4);
        repeat (5) @(negedge clk_i);
        for (int k = 0; k < 3; k++) write_byte(8'hFF);
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (!txd) lows++;
        end
        check("cts_held_txd", lows, 0);
        check("cts_held_idle", tx_idle_o, 1'b0);
        cts_drv = 1'b1;
        wait_txd_low("cts_start");
        n = 0; starts = 1; prev = 1'b0;
        while (!tx_idle_o && n < 1000) begin
            @(negedge clk_i);
            n++;
            if (prev && !txd) starts++;
            prev = txd;
        end
        check("cts_frames", starts, 3);
        check("cts_span", n, 122);
        cfg(2'd3, 2'd0, 1'b0, 16'd16);
        for (int k = 0; k < 3; k++) write_byte(8'h00);
        wait_txd_low("mid_start");
        repeat (5) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("mid_rst_txd", txd, 1'b1);
        check("mid_rst_level", rx_level_o, 3'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("mid_rst_fifo_empty", tx_idle_o, 1'b1);
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (!txd) lows++;
        end
        check("mid_rst_quiet", lows, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
